// File: rtl/key_loader_pkg.sv
// key_loader shared constants: default key width, failure limit, FSM encoding.
package key_loader_pkg;

   localparam int KEY_SIZE_DEF  = 4;
   localparam int MAX_FAILS_DEF = 3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SHIFT = 2'd1;
   localparam state_t ST_CHECK = 2'd2;
   localparam state_t ST_LOCK  = 2'd3;

endpackage

// File: rtl/key_shift_par.sv
// MSB-first key shift register with a running XOR of every bit shifted in.
module key_shift_par #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         shift_i,
   input  logic         d_i,
   output logic [W-1:0] q_o,
   output logic         par_o
);

   logic [W-1:0] q_q;
   logic         par_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
         q_q   <= '0;
         par_q <= 1'b0;
      end else if (shift_i) begin
         q_q   <= {q_q[W-2:0], d_i};
         par_q <= par_q ^ d_i;
      end
   end

   assign q_o   = q_q;
   assign par_o = par_q;

endmodule

// File: rtl/key_loader.sv
// Serial key loader with even-parity check and held key output.
// Define KEY_LOADER_LOCKOUT_EN to lock out after MAX_FAILS consecutive bad frames.
module key_loader
   import key_loader_pkg::*;
#(
   parameter int KEY_SIZE  = KEY_SIZE_DEF,
   parameter int MAX_FAILS = MAX_FAILS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ser_start,
   input  logic                ser_valid,
   input  logic                ser_data,
   output logic [KEY_SIZE-1:0] key,
   output logic                key_valid,
   output logic                key_update,
   output logic                busy,
   output logic                error,
   output logic                locked_out
);

   localparam int CW = $clog2(KEY_SIZE + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(KEY_SIZE);

   if (KEY_SIZE < 2) begin : g_bad_ks
      $error("key_loader: KEY_SIZE must be >= 2");
   end
   if (MAX_FAILS < 1) begin : g_bad_mf
      $error("key_loader: MAX_FAILS must be >= 1");
   end

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [KEY_SIZE-1:0] key_q, key_d;
   logic                kv_q, kv_d;
   logic                upd_q, upd_d;
   logic                err_q, err_d;
   logic                pb_q, pb_d;
   logic [KEY_SIZE-1:0] sh;
   logic                par, clr, shift, pass, start;

`ifdef KEY_LOADER_LOCKOUT_EN
   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam logic [FW-1:0] FMAX = FW'(MAX_FAILS);
   logic [FW-1:0] fails_q, fails_d;
`endif

   key_shift_par #(.W(KEY_SIZE)) u_shift (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (clr),
      .shift_i (shift),
      .d_i     (ser_data),
      .q_o     (sh),
      .par_o   (par)
   );

   assign start = ser_start && (state_q != ST_LOCK);
   assign pass  = ~(par ^ pb_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      kv_d    = kv_q;
      upd_d   = 1'b0;
      err_d   = err_q;
      pb_d    = pb_q;
      clr     = 1'b0;
      shift   = 1'b0;
`ifdef KEY_LOADER_LOCKOUT_EN
      fails_d = fails_q;
`endif
      // A start strobe aborts whatever frame is in flight.
      if (start) begin
         state_d = ST_SHIFT;
         clr     = 1'b1;
         cnt_d   = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            ST_SHIFT: begin
               if (ser_valid) begin
                  if (cnt_q != CNT_MAX) begin
                     shift = 1'b1;
                     cnt_d = cnt_q + CW'(1);
                  end else begin
                     pb_d    = ser_data;
                     state_d = ST_CHECK;
                  end
               end
            end
            ST_CHECK: begin
               state_d = ST_IDLE;
               if (pass) begin
                  key_d = sh;
                  kv_d  = 1'b1;
                  upd_d = 1'b1;
`ifdef KEY_LOADER_LOCKOUT_EN
                  fails_d = '0;
`endif
               end else begin
                  err_d = 1'b1;
`ifdef KEY_LOADER_LOCKOUT_EN
                  fails_d = (fails_q == FMAX) ? fails_q : fails_q + FW'(1);
                  if (fails_d == FMAX) state_d = ST_LOCK;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         key_q   <= '0;
         kv_q    <= 1'b0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
         pb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         kv_q    <= kv_d;
         upd_q   <= upd_d;
         err_q   <= err_d;
         pb_q    <= pb_d;
      end
   end

`ifdef KEY_LOADER_LOCKOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) fails_q <= '0;
      else        fails_q <= fails_d;
   end
   assign locked_out = (state_q == ST_LOCK);
`else
   assign locked_out = 1'b0;
`endif

   assign key        = key_q;
   assign key_valid  = kv_q;
   assign key_update = upd_q;
   assign error      = err_q;
   assign busy       = (state_q == ST_SHIFT) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_key_loader.sv
// Randomized frame-level bench for key_loader against a transaction model.
module tb_key_loader;

   localparam int KS = 4;
   localparam int MF = 3;

   logic          clk = 1'b0;
   logic          rst_n, ser_start, ser_valid, ser_data;
   logic [KS-1:0] key;
   logic          key_valid, key_update, busy, error, locked_out;

   int n_vec = 0;
   int n_bad = 0;
   int upd_cnt = 0;

   logic [KS-1:0] m_key;
   logic          m_kv, m_err, m_lock;
   int            m_fails;

   key_loader #(.KEY_SIZE(KS), .MAX_FAILS(MF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ser_start  (ser_start),
      .ser_valid  (ser_valid),
      .ser_data   (ser_data),
      .key        (key),
      .key_valid  (key_valid),
      .key_update (key_update),
      .busy       (busy),
      .error      (error),
      .locked_out (locked_out)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (key_update === 1'b1) upd_cnt++;
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) begin
         ser_data = 1'($urandom);
         tick();
      end
   endtask

   task automatic send_bit(logic b);
      ser_valid = 1'b1;
      ser_data  = b;
      tick();
      ser_valid = 1'b0;
      gap();
   endtask

   task automatic do_start(bit with_valid);
      ser_start = 1'b1;
      ser_valid = with_valid;
      ser_data  = 1'($urandom);
      tick();
      ser_start = 1'b0;
      ser_valid = 1'b0;
   endtask

   task automatic m_reset();
      m_key   = '0;
      m_kv    = 1'b0;
      m_err   = 1'b0;
      m_lock  = 1'b0;
      m_fails = 0;
   endtask

   task automatic check_outs(string tag, int exp_upd);
      check({tag, "_key"},  32'(key),        32'(m_key));
      check({tag, "_kv"},   32'(key_valid),  32'(m_kv));
      check({tag, "_err"},  32'(error),      32'(m_err));
      check({tag, "_busy"}, 32'(busy),       32'(0));
      check({tag, "_lock"}, 32'(locked_out), 32'(m_lock));
      check({tag, "_upd"},  32'(upd_cnt),    32'(exp_upd));
   endtask

   task automatic frame(string tag, logic [KS-1:0] bits, logic par,
                        int abort_at, bit sv);
      int exp_upd;
      exp_upd = 0;
      do_start(sv);
      check({tag, "_busy_st"}, 32'(busy), 32'(!m_lock));
      if (!m_lock) check({tag, "_err_clr"}, 32'(error), 32'(0));
      if (abort_at > 0) begin
         for (int i = 0; i < abort_at; i++) send_bit(1'($urandom));
         do_start(1'b0);
      end
      upd_cnt = 0;
      for (int i = KS - 1; i >= 0; i--) send_bit(bits[i]);
      ser_valid = 1'b1;
      ser_data  = par;
      tick();
      ser_valid = 1'b0;
      repeat (3) tick();
      if (!m_lock) begin
         if (((^bits) ^ par) == 1'b0) begin
            m_key   = bits;
            m_kv    = 1'b1;
            m_err   = 1'b0;
            m_fails = 0;
            exp_upd = 1;
         end else begin
            m_err   = 1'b1;
            m_fails = (m_fails < MF) ? m_fails + 1 : MF;
`ifdef KEY_LOADER_LOCKOUT_EN
            if (m_fails == MF) m_lock = 1'b1;
`endif
         end
      end
      check_outs(tag, exp_upd);
   endtask

   task automatic do_reset(string tag);
      rst_n = 1'b0;
      tick();
      m_reset();
      upd_cnt = 0;
      check_outs(tag, 0);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [KS-1:0] rb;
      logic          rp;
      rst_n     = 1'b0;
      ser_start = 1'b0;
      ser_valid = 1'b0;
      ser_data  = 1'b0;
      m_reset();
      tick();
      tick();
      upd_cnt = 0;
      check_outs("reset", 0);
      rst_n = 1'b1;
      tick();

      frame("good_b",  4'hB, 1'b1, 0, 1'b0);
      frame("bad_6",   4'h6, 1'b1, 0, 1'b0);
      frame("abort_3", 4'h3, 1'b0, 2, 1'b0);
      frame("sv_5",    4'h5, 1'b0, 0, 1'b1);
      frame("same_5",  4'h5, 1'b0, 0, 1'b0);

      do_start(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      do_reset("mid_rst");

      for (int i = 0; i < 4; i++) begin
         ser_valid = 1'b1;
         ser_data  = 1'($urandom);
         tick();
      end
      ser_valid = 1'b0;
      upd_cnt = 0;
      tick();
      check_outs("idle_valid", 0);

      frame("pre_9", 4'h9, 1'b0, 0, 1'b0);
      frame("bad1",  4'h1, 1'b0, 0, 1'b0);
      frame("bad2",  4'h2, 1'b0, 0, 1'b0);
      frame("bad3",  4'h4, 1'b0, 0, 1'b0);
      frame("after", 4'hA, 1'b0, 0, 1'b0);
      do_reset("lock_rst");

      for (int n = 0; n < 40; n++) begin
         rb = KS'($urandom);
         rp = (^rb) ^ ($urandom_range(0, 3) == 0);
         frame("rand", rb, rp,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, KS)) : 0,
               1'($urandom_range(0, 3) == 0));
      end
      do_reset("end_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
